rsa_stream_loader: RTL

- Host-side sequencer that sits directly upstream of the RSA exponentiation core.
- Accepts a byte stream (modulus, exponent, message) from the PCIe receive FIFO.
- Drives the core's byte-wide register write port, pulses start, and waits for the core to finish.
- Reads back the 256-bit result byte by byte and streams it to the PCIe transmit FIFO under valid/ready flow control. It also records the core's computation cycle count.

---
 rtl/rsa_stream_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rsa_stream_loader.sv
// Host-side sequencer for the RSA exponentiation core: loads modulus/exponent/message
// from a byte stream, starts the core, times it, and streams the result back out.
module rsa_stream_loader #(
   parameter int NBYTES = 32,
   parameter int CYC_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   input  logic             out_ready,
   output logic             core_we,
   output logic             core_oe,
   output logic             core_start,
   output logic [1:0]       core_reg_sel,
   output logic [4:0]       core_addr,
   output logic [7:0]       core_wdata,
   input  logic [7:0]       core_rdata,
   input  logic             core_ready,
   output logic             busy,
   output logic [CYC_W-1:0] last_cycles
);

   typedef enum logic [3:0] {
      IDLE, LOAD_N, LOAD_E, LOAD_M, START, SKIP, BUSY, RD_ADDR, RD_CAP, RD_OUT
   } state_t;

   localparam logic [4:0] TOP_ADDR = 5'(NBYTES - 1);

   state_t           state, next_state;
   logic [4:0]       wr_idx;
   logic [CYC_W-1:0] cyc_cnt;
   logic             loading, accept, handshake, last_byte;

   logic             in_ready_d, core_we_d, core_start_d, core_oe_d, out_valid_d, busy_d;
   logic [1:0]       sel_d;

   assign loading   = state inside {IDLE, LOAD_N, LOAD_E, LOAD_M};
   assign accept    = in_valid && in_ready && loading;
   assign handshake = (state == RD_OUT) && out_valid && out_ready;
   assign last_byte = (wr_idx == '0);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = last_byte ? LOAD_E : LOAD_N;
         LOAD_N:  if (accept && last_byte) next_state = LOAD_E;
         LOAD_E:  if (accept && last_byte) next_state = LOAD_M;
         LOAD_M:  if (accept && last_byte) next_state = START;
         START:   next_state = SKIP;
         SKIP:    next_state = BUSY;
         BUSY:    if (core_ready) next_state = RD_ADDR;
         RD_ADDR: next_state = RD_CAP;
         RD_CAP:  next_state = RD_OUT;
         RD_OUT:  if (handshake) next_state = (core_addr == '0) ? IDLE : RD_ADDR;
         default: next_state = IDLE;
      endcase
   end

   // Registered strobes: read-side enables follow next_state so they line up with
   // the read states; core_start trails START so it lands one cycle after the last write.
   always_comb begin
      in_ready_d   = next_state inside {IDLE, LOAD_N, LOAD_E, LOAD_M};
      core_we_d    = accept;
      core_start_d = (state == START);
      core_oe_d    = next_state inside {RD_ADDR, RD_CAP, RD_OUT};
      out_valid_d  = (next_state == RD_OUT);
      busy_d       = (next_state != IDLE);
      case (state)
         LOAD_E:  sel_d = 2'b10;
         LOAD_M:  sel_d = 2'b00;
         default: sel_d = 2'b11;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         core_we      <= 1'b0;
         core_oe      <= 1'b0;
         core_start   <= 1'b0;
         core_reg_sel <= '0;
         core_addr    <= '0;
         core_wdata   <= '0;
         busy         <= 1'b0;
         last_cycles  <= '0;
         cyc_cnt      <= '0;
         wr_idx       <= TOP_ADDR;
      end else begin
         in_ready   <= in_ready_d;
         core_we    <= core_we_d;
         core_start <= core_start_d;
         core_oe    <= core_oe_d;
         out_valid  <= out_valid_d;
         busy       <= busy_d;

         if (accept) begin
            core_addr    <= wr_idx;
            core_wdata   <= in_data;
            core_reg_sel <= sel_d;
            wr_idx       <= last_byte ? TOP_ADDR : wr_idx - 5'd1;
         end

         case (state)
            SKIP: cyc_cnt <= CYC_W'(1);
            BUSY: begin
               if (core_ready) begin
                  last_cycles <= cyc_cnt;
                  core_addr   <= TOP_ADDR;
               end else if (cyc_cnt != '1) begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            RD_CAP: out_data <= core_rdata;
            RD_OUT: if (handshake && core_addr != '0) core_addr <= core_addr - 5'd1;
            default: ;
         endcase
      end
   end

endmodule
